// File: rtl/fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fetch_queue                                                  |
// | Description : Instruction fetch stage. Owns the fetch PC, issues word      |
// |               fetches over a variable-latency req/ack handshake and keeps  |
// |               a 2-entry {instr, seq_PC} queue whose head feeds decode.     |
// |               Handles branch/jump redirects and HALT detection.            |
// | Optional    : FETCH_ALIGN_CHK_EN - a redirect to an odd address sets the   |
// |               sticky err flag and forces HALT; otherwise err is tied 0.    |
// | Ports       : clk, rst (async, active-low)                                 |
// |               imem_req/imem_addr   -> fetch request, held until imem_ack   |
// |               imem_ack/imem_data   <- returned instruction word            |
// |               redirect/redirect_pc <- taken branch/jump target             |
// |               stall                <- decode cannot take the head          |
// |               instruc/seq_PC/valid -> queue head to decode                 |
// |               halted               -> HALT fetched and queue drained       |
// |               err                  -> sticky misaligned-redirect flag      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fetch_queue #(
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  stall,
  output logic [DATA_WIDTH-1:0] instruc,
  output logic [DATA_WIDTH-1:0] seq_PC,
  output logic                  valid,
  output logic                  halted,
  output logic                  err
);

  localparam logic [1:0] ST_IDLE = 2'd0;  // no request outstanding
  localparam logic [1:0] ST_BUSY = 2'd1;  // live request outstanding
  localparam logic [1:0] ST_DROP = 2'd2;  // stale request outstanding
  localparam logic [1:0] ST_HALT = 2'd3;  // HALT fetched, no more requests

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(2);

  logic [1:0]                 state_q, state_d;
  logic [DATA_WIDTH-1:0]      pc_q, pc_d;
  logic [DATA_WIDTH-1:0]      addr_q, addr_d;
  logic                       req_q, req_d;
  logic [1:0]                 count_q, count_d;
  logic [1:0][DATA_WIDTH-1:0] instr_q, instr_d;
  logic [1:0][DATA_WIDTH-1:0] seq_q, seq_d;

  logic       pop;
  logic       push;
  logic       push_halt;
  logic       redir;
  logic       bad_align;
  logic [1:0] count_pop;

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q, err_d;

  // Once err is set the front end is parked: later redirects are ignored.
  assign redir     = redirect && !err_q;
  assign bad_align = redir && redirect_pc[0];
  assign err_d     = err_q | bad_align;
  assign err       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign redir     = redirect;
  assign bad_align = 1'b0;
  assign err       = 1'b0;
`endif

  assign pop       = (count_q != 2'd0) && !stall;
  // Data returning for a request that a same-cycle redirect kills is dropped.
  assign push      = (state_q == ST_BUSY) && imem_ack && !redir;
  assign push_halt = push && (imem_data[DATA_WIDTH-1 -: 5] == 5'b00000);
  // Occupancy after the pop but before the push; a push lands in this slot.
  assign count_pop = count_q - {1'b0, pop};

  // Queue: entry 0 is the head, a pop shifts entry 1 down.
  always_comb begin
    instr_d = instr_q;
    seq_d   = seq_q;
    if (pop) begin
      instr_d[0] = instr_q[1];
      seq_d[0]   = seq_q[1];
    end
    if (push) begin
      instr_d[count_pop[0]] = imem_data;
      seq_d[count_pop[0]]   = addr_q + PC_STEP;
    end
    // Redirect beats pop and push: the queue is empty next cycle.
    count_d = redir ? 2'd0 : (count_pop + {1'b0, push});
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    case (state_q)
      ST_IDLE: begin
        if (redir) begin
          pc_d = redirect_pc;
          if (bad_align) begin
            state_d = ST_HALT;
          end
        end else if (count_pop != 2'd2) begin
          // A fetch is only issued once a queue slot is guaranteed.
          addr_d  = pc_q;
          req_d   = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (redir) begin
          pc_d = redirect_pc;
          if (imem_ack) begin
            if (bad_align) begin
              req_d   = 1'b0;
              state_d = ST_HALT;
            end else begin
              addr_d = redirect_pc;
            end
          end else begin
            // Request must stay on the bus until acked; its data is junk.
            state_d = ST_DROP;
          end
        end else if (imem_ack) begin
          pc_d = pc_q + PC_STEP;
          if (push_halt) begin
            req_d   = 1'b0;
            state_d = ST_HALT;
          end else if (count_pop == 2'd0) begin
            // After this push one slot is still free: fetch back-to-back.
            addr_d = pc_q + PC_STEP;
          end else begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DROP: begin
        if (redir) begin
          pc_d = redirect_pc;
        end
        if (imem_ack) begin
`ifdef FETCH_ALIGN_CHK_EN
          if (err_d) begin
            req_d   = 1'b0;
            state_d = ST_HALT;
          end else begin
            addr_d  = redir ? redirect_pc : pc_q;
            state_d = ST_BUSY;
          end
`else
          addr_d  = redir ? redirect_pc : pc_q;
          state_d = ST_BUSY;
`endif
        end
      end
      ST_HALT: begin
        // Wrong-path HALT recovery; a misaligned target keeps us parked.
        if (redir) begin
          pc_d = redirect_pc;
          if (!bad_align) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      count_q <= 2'd0;
      instr_q <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      count_q <= count_d;
      instr_q <= instr_d;
      seq_q   <= seq_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign instruc   = instr_q[0];
  assign seq_PC    = seq_q[0];
  assign valid     = (count_q != 2'd0);
  assign halted    = (state_q == ST_HALT) && (count_q == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fetch_queue                                               |
// | Description : Self-checking bench for fetch_queue. A transaction-level     |
// |               model tracks the expected instruction stream, the queue      |
// |               contents and the fetch-address sequence; a memory model      |
// |               answers requests with random latency.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fetch_queue;

  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef FETCH_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [15:0] instruc;
  logic [15:0] seq_PC;
  logic        valid;
  logic        halted;
  logic        err;

  fetch_queue #(
    .DATA_WIDTH (16),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instruc     (instruc),
    .seq_PC      (seq_PC),
    .valid       (valid),
    .halted      (halted),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] seq;
  } ent_t;

  // Reference model state
  ent_t        q[$];
  logic [15:0] nextfetch, out_addr, prev_addr, last_issue_addr;
  logic        prev_req, prev_ack, stale, halt_pending, err_m, err_wait;
  logic        idle_expect, last_issue;
  int          wait_cnt, lat_min, lat_max;
  bit          rand_mode, halt_en;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents
  function automatic logic [15:0] memdata(input logic [15:0] a);
    if (rand_mode) begin
      if (((a >> 1) % 13) == 5) return {5'b00000, a[10:0]};
      return 16'h8000 | (a ^ 16'h1357);
    end
    if (halt_en && a == 16'h0010) return 16'h0000;
    return 16'h1000 + (a >> 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst         = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_data   = '0;
    #1;
    check_eq("rst_req",     imem_req,  0);
    check_eq("rst_addr",    imem_addr, RST_PC);
    check_eq("rst_valid",   valid,     0);
    check_eq("rst_halted",  halted,    0);
    check_eq("rst_err",     err,       0);
    check_eq("rst_instruc", instruc,   0);
    check_eq("rst_seq",     seq_PC,    0);
    repeat (2) @(negedge clk);
    q.delete();
    nextfetch    = RST_PC;
    out_addr     = RST_PC;
    prev_addr    = RST_PC;
    prev_req     = 1'b0;
    prev_ack     = 1'b0;
    stale        = 1'b0;
    halt_pending = 1'b0;
    err_m        = 1'b0;
    err_wait     = 1'b0;
    idle_expect  = 1'b1;
    last_issue   = 1'b0;
    wait_cnt     = 0;
    rst          = 1'b1;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model.
  task automatic cycle(input logic st, input logic rd, input logic [15:0] rpc);
    logic new_issue, ack, eff;
    ent_t e;
    @(negedge clk);
    new_issue  = imem_req && (!prev_req || prev_ack);
    last_issue = new_issue;
    if (prev_req && !prev_ack) begin
      check_eq("req_hold",  imem_req,  1);
      check_eq("addr_hold", imem_addr, prev_addr);
    end
    if (idle_expect) check_eq("idle_issue", imem_req, 1);
    if (new_issue) begin
      check_eq("fetch_addr",         imem_addr, nextfetch);
      check_eq("fetch_while_halted", halt_pending | err_m, 0);
      check_eq("fetch_slot_free",    q.size() < 2, 1);
      last_issue_addr = imem_addr;
      out_addr        = nextfetch;
      stale           = 1'b0;
      wait_cnt        = $urandom_range(lat_min, lat_max);
    end
    check_eq("valid", valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("instruc", instruc, q[0].instr);
      check_eq("seq_PC",  seq_PC,  q[0].seq);
    end
    check_eq("halted", halted, (halt_pending || (err_m && !err_wait)) && q.size() == 0);
    check_eq("err", err, err_m);

    ack = imem_req && (wait_cnt == 0);
    if (imem_req && wait_cnt > 0) wait_cnt--;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = ack;
    imem_data   = ack ? memdata(imem_addr) : 16'($urandom);

    eff = rd && !err_m;
    if (q.size() != 0 && !st) void'(q.pop_front());
    if (ack) begin
      if (!stale && !eff) begin
        e.instr = memdata(out_addr);
        e.seq   = out_addr + 16'd2;
        q.push_back(e);
        nextfetch = out_addr + 16'd2;
        if (e.instr[15:11] == 5'b00000) halt_pending = 1'b1;
      end
      err_wait = 1'b0;
    end
    if (eff) begin
      q.delete();
      nextfetch    = rpc;
      halt_pending = 1'b0;
      if (imem_req && !ack) stale = 1'b1;
      if (ALIGN_CHK && rpc[0]) begin
        err_m    = 1'b1;
        err_wait = imem_req && !ack;
      end
    end
    check_eq("queue_depth", q.size() <= 2, 1);
    idle_expect = !imem_req && !eff && !halt_pending && !err_m && (q.size() < 2);
    prev_req  = imem_req;
    prev_ack  = ack;
    prev_addr = imem_addr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen;
    logic [31:0] r;
    logic [15:0] rpc;
    rand_mode = 1'b0;
    halt_en   = 1'b0;
    lat_min   = 0;
    lat_max   = 0;
    do_reset();

    // Zero-wait memory: one instruction per cycle from RESET_PC.
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("first_req",  imem_req,  1);
    check_eq("first_addr", imem_addr, RST_PC);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("valid_cycle2", valid,  1);
    check_eq("first_seq",    seq_PC, 16'h0002);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      check_eq("stream_valid", valid, 1);
    end

    // Redirect, ack and pop in the same cycle.
    cycle(1'b0, 1'b1, 16'h0100);
    cycle(1'b0, 1'b0, 16'h0);
    check_eq("redir_flush", valid, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'h0);

    // Stall fills both slots and fetch pauses, then resumes.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h0);
    check_eq("stall_req_drop", imem_req, 0);
    check_eq("stall_valid",    valid,    1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 16'h0);

    // Redirect while a 3-cycle request is waiting.
    lat_min = 3;
    lat_max = 3;
    seen    = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      seen = last_issue;
    end
    check_eq("slow_issue_seen", seen, 1);
    cycle(1'b0, 1'b1, 16'h0040);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      if (last_issue && last_issue_addr == 16'h0040) seen = 1'b1;
    end
    check_eq("refetch_0040", seen, 1);

    // HALT word at 0x0010, then recovery by redirect.
    lat_min = 1;
    lat_max = 1;
    halt_en = 1'b1;
    cycle(1'b0, 1'b1, 16'h000C);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 16'h0);
    check_eq("halt_halted", halted,   1);
    check_eq("halt_no_req", imem_req, 0);
    cycle(1'b0, 1'b1, 16'h0020);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      if (last_issue && last_issue_addr == 16'h0020) seen = 1'b1;
    end
    check_eq("halt_resume", seen,   1);
    check_eq("halt_clear",  halted, 0);
    halt_en = 1'b0;

    // Random traffic, with a reset in the middle of it.
    rand_mode = 1'b1;
    lat_min   = 0;
    lat_max   = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      r   = $urandom;
      rpc = ((r[7:0] % 8) == 0) ? 16'hFFFC : (r[31:16] & 16'hFFFE);
      cycle(($urandom % 4) == 0, ($urandom % 16) == 0, rpc);
    end

    // Misaligned redirect target.
    rand_mode = 1'b0;
    lat_min   = 1;
    lat_max   = 1;
    cycle(1'b0, 1'b1, 16'h0031);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 16'h0);
      if (last_issue && last_issue_addr == 16'h0031) seen = 1'b1;
    end
`ifdef FETCH_ALIGN_CHK_EN
    check_eq("align_err",    err,      1);
    check_eq("align_no_req", imem_req, 0);
    check_eq("align_halted", halted,   1);
    check_eq("align_no_odd", seen,     0);
`else
    check_eq("odd_fetch", seen, 1);
    check_eq("odd_err",   err,  0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
